regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_clear_fsm.sv | 63 ++++++
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the multi-read-port register file
//
// Purpose : state encoding for the clear engine, depth and byte-count helpers.
// Ports   : none (package).
// Options : REGFILE_BYPASS_EN (used by regfile_mp) enables same-cycle write forwarding.

package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int BYTE_BITS = 8;

  function automatic int calc_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int bytes_per_word(input int data_width);
    return data_width / BYTE_BITS;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - sequential clear engine for the register file
//
// Purpose : walks clr_addr_o over every entry after reset or on clear_i and
//           raises clr_we_o while doing so; busy_o marks the CLEAR state.
// Ports   : clk, rst (async, active-high), clear_i (sampled only in READY),
//           busy_o, clr_we_o, clr_addr_o[ADDR_WIDTH-1:0].
// Options : none.

module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  output logic                  busy_o,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          // The last entry (all-ones address) is zeroed on this edge.
          if (r_cnt == '1) begin
            r_state <= ST_READY;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (clear_i) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign busy_o     = r_busy;
  assign clr_we_o   = r_busy;
  assign clr_addr_o = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-read-port register file with clear engine
//
// Purpose : DEPTH x DATA_WIDTH array, one byte-enabled write port, NUM_READ
//           combinational read ports, optional hardwired zero register.
// Ports   : clk, rst (async, active-high), clear_i, busy_o,
//           wr_en_i, wr_addr_i, wr_be_i, wr_data_i,
//           rd_addr_i[NUM_READ*ADDR_WIDTH], rd_data_o[NUM_READ*DATA_WIDTH].
// Options : REGFILE_BYPASS_EN - forward the current write into matching reads.

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear_i,
  output logic                           busy_o,
  input  logic                           wr_en_i,
  input  logic [ADDR_WIDTH-1:0]          wr_addr_i,
  input  logic [DATA_WIDTH/8-1:0]        wr_be_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH  = calc_depth(ADDR_WIDTH);
  localparam int NBYTES = bytes_per_word(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_busy;
  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_wr_zero;
  logic                  w_wr_ok;

  regfile_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_fsm (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear_i),
    .busy_o     (w_busy),
    .clr_we_o   (w_clr_we),
    .clr_addr_o (w_clr_addr)
  );

  assign busy_o    = w_busy;
  assign w_wr_zero = (ZERO_REG != 0) && (wr_addr_i == '0);
  // clear_i wins over a same-cycle write; writes while busy are dropped.
  assign w_wr_ok   = wr_en_i && !w_busy && !clear_i && !w_wr_zero;

  // Array has no reset of its own; the clear engine zeroes it after rst.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_ok) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_be_i[b]) begin
          r_mem[wr_addr_i][b*BYTE_BITS +: BYTE_BITS] <= wr_data_i[b*BYTE_BITS +: BYTE_BITS];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_stored;
    logic [DATA_WIDTH-1:0] w_fwd;
    logic                  w_force_zero;

    assign w_addr   = rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_stored = r_mem[w_addr];

`ifdef REGFILE_BYPASS_EN
    // Byte-wise merge of the in-flight write over the stored word.
    always_comb begin
      w_fwd = w_stored;
      if (wr_en_i && (w_addr == wr_addr_i)) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (wr_be_i[b]) begin
            w_fwd[b*BYTE_BITS +: BYTE_BITS] = wr_data_i[b*BYTE_BITS +: BYTE_BITS];
          end
        end
      end
    end
`else
    assign w_fwd = w_stored;
`endif

    // CLEAR forces zero on every port, which also disables forwarding there.
    assign w_force_zero = w_busy || ((ZERO_REG != 0) && (w_addr == '0));
    assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = w_force_zero ? '0 : w_fwd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed scoreboard bench for regfile_mp

module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_i = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data_a;
  logic [63:0] rd_data_b;
  logic        busy_a;
  logic        busy_b;

  int n_vec = 0;
  int n_err = 0;
  int last_len = 0;

  localparam int SEL_P0   = 0;
  localparam int SEL_P1   = 1;
  localparam int SEL_BUSY = 2;
  localparam int SEL_B0   = 3;
  localparam int SEL_LEN  = 4;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'hCAFEF00D;
`else
  localparam logic [31:0] BYP_EXP = 32'h0000_0000;
`endif

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1)) u_dut_a (
    .clk(clk), .rst(rst), .clear_i(clear_i), .busy_o(busy_a),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_a)
  );

  regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(0)) u_dut_b (
    .clk(clk), .rst(rst), .clear_i(clear_i), .busy_o(busy_b),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_b)
  );

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_P0:   return rd_data_a[31:0];
      SEL_P1:   return rd_data_a[63:32];
      SEL_BUSY: return {31'b0, busy_a};
      SEL_B0:   return rd_data_b[31:0];
      default:  return last_len;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_vec++;
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Called at negedge+1; counts consecutive negedges with busy high.
  task automatic count_busy();
    last_len = 0;
    while (busy_a && last_len < 200) begin
      last_len++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 1; a < 32; a++) begin
      rd_addr = {5'(a), 5'(31 - a + 1)};
      #1;
      push({tag, "_p0"}, SEL_P0, 32'h0);
      push({tag, "_p1"}, SEL_P1, 32'h0);
      check_sb();
    end
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    // Reset state
    rd_addr = {5'd6, 5'd5};
    tick();
    #1;
    push("rst_busy", SEL_BUSY, 32'h1);
    push("rst_rd0", SEL_P0, 32'h0);
    push("rst_rd1", SEL_P1, 32'h0);
    check_sb();

    // Release reset, clear takes 32 cycles
    rst = 1'b0;
    #1;
    count_busy();
    push("rst_clear_len", SEL_LEN, 32'd32);
    push("rst_busy_low", SEL_BUSY, 32'h0);
    check_sb();
    check_all_zero("init_zero");

    // Partial byte write merge
    tick();
    write(5'd5, 32'hDEADBEEF, 4'hF);
    write(5'd5, 32'h11223344, 4'h3);
    rd_addr = {5'd5, 5'd5};
    #1;
    push("be_merge_p0", SEL_P0, 32'hDEAD3344);
    push("be_merge_p1", SEL_P1, 32'hDEAD3344);
    check_sb();

    // be = 0 is a no-op
    write(5'd5, 32'hFFFFFFFF, 4'h0);
    #1;
    push("be_zero_noop", SEL_P0, 32'hDEAD3344);
    check_sb();

    // Zero register
    write(5'd0, 32'hFFFFFFFF, 4'hF);
    rd_addr = {5'd5, 5'd0};
    #1;
    push("zero_reg_a", SEL_P0, 32'h0);
    push("zero_reg_b", SEL_B0, 32'hFFFFFFFF);
    check_sb();

    // Same-cycle forwarding (or old value without bypass)
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
    rd_addr = {5'd7, 5'd5};
    #1;
    push("bypass_same", SEL_P1, BYP_EXP);
    push("bypass_other", SEL_P0, 32'hDEAD3344);
    check_sb();
    tick();
    wr_en = 1'b0;
    #1;
    push("write_next", SEL_P1, 32'hCAFEF00D);
    check_sb();

    // clear_i beats a same-cycle write; writes during busy are dropped
    write(5'd3, 32'hAAAA5555, 4'hF);
    rd_addr = {5'd4, 5'd3};
    #1;
    push("pre_clear_a3", SEL_P0, 32'hAAAA5555);
    check_sb();
    clear_i = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678; wr_be = 4'hF;
    tick();
    clear_i = 1'b0;
    wr_addr = 5'd4; wr_data = 32'h00000044;
    #1;
    push("clr_busy_rise", SEL_BUSY, 32'h1);
    push("clr_rd_forced0", SEL_P0, 32'h0);
    check_sb();
    count_busy();
    wr_en = 1'b0;
    push("clr_len", SEL_LEN, 32'd32);
    check_sb();
    #1;
    push("clr_drop_a3", SEL_P0, 32'h0);
    push("busy_drop_a4", SEL_P1, 32'h0);
    check_sb();
    check_all_zero("clr_zero");

    // rst in the middle of a clear restarts it
    tick();
    write(5'd9, 32'h99999999, 4'hF);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    #1;
    push("midrst_busy", SEL_BUSY, 32'h1);
    check_sb();
    tick();
    rst = 1'b0;
    #1;
    count_busy();
    push("midrst_len", SEL_LEN, 32'd32);
    push("midrst_busy_low", SEL_BUSY, 32'h0);
    check_sb();
    check_all_zero("midrst_zero");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
